// File: rtl/ddr3_odt_dly_pkg.sv
// Shared types and encodings for the DDR3 ODT output delay-line sequencer.
package ddr3_odt_dly_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETUP,
      S_PULSE,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_OOR   = 2'b01;
   localparam logic [1:0] ST_CLAMP = 2'b10;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/ddr3_odt_dly_ctrl.sv
// Sequences LOAD/MOVE/DIRECTION strobes for the ODT IOD output delay line and tracks the tap.
// Optional macro DDR3_ODT_DLY_STATS_EN adds saturating move_cnt/oor_cnt statistics outputs.
module ddr3_odt_dly_ctrl
   import ddr3_odt_dly_pkg::*;
#(
   parameter int TAP_W       = 8,
   parameter int MAX_TAP     = 255,
   parameter int INIT_TAP    = 1,
   parameter int MOVE_GAP    = 4,
   parameter int LOAD_CYCLES = 2
) (
   input  logic             fab_clk,
   input  logic             arst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_load,
   input  logic             req_dir,
   input  logic [TAP_W-1:0] req_steps,
   output logic             done,
   output logic [1:0]       done_status,
   output logic             busy,
   output logic [TAP_W-1:0] tap_pos,
   output logic             delay_line_move,
   output logic             delay_line_direction,
   output logic             delay_line_load,
`ifdef DDR3_ODT_DLY_STATS_EN
   output logic [15:0]      move_cnt,
   output logic [7:0]       oor_cnt,
`endif
   input  logic             delay_line_out_of_range
);

   localparam logic [TAP_W-1:0] MAX_TAP_V  = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);
   localparam logic [TAP_W-1:0] ONE_V      = TAP_W'(1);

   state_t           state;
   logic [TAP_W-1:0] remaining;
   logic [3:0]       gap_cnt;
   logic [2:0]       load_cnt;
   logic             at_limit;

   // A step is refused when the tracked position already sits on the edge it would cross.
   assign at_limit = (delay_line_direction == DIR_INC) ? (tap_pos == MAX_TAP_V)
                                                       : (tap_pos == '0);

   // NOTE: every register, including the counters, is cleared by the async reset so an
   // aborted request leaves no stale state; all state updates use non-blocking assignment.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         state                <= S_IDLE;
         req_ready            <= 1'b0;
         done                 <= 1'b0;
         done_status          <= ST_OK;
         busy                 <= 1'b0;
         tap_pos              <= INIT_TAP_V;
         delay_line_move      <= 1'b0;
         delay_line_direction <= 1'b0;
         delay_line_load      <= 1'b0;
         remaining            <= '0;
         gap_cnt              <= '0;
         load_cnt             <= '0;
`ifdef DDR3_ODT_DLY_STATS_EN
         move_cnt             <= '0;
         oor_cnt              <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready            <= 1'b0;
                  busy                 <= 1'b1;
                  delay_line_direction <= req_dir;
                  remaining            <= req_steps;
                  if (req_load) begin
                     state           <= S_LOAD;
                     delay_line_load <= 1'b1;
                     load_cnt        <= 3'(LOAD_CYCLES - 1);
`ifdef DDR3_ODT_DLY_STATS_EN
                     move_cnt        <= '0;
                     oor_cnt         <= '0;
`endif
                  end else begin
                     state <= S_SETUP;
                  end
               end
            end

            S_LOAD: begin
               if (load_cnt == '0) begin
                  delay_line_load <= 1'b0;
                  tap_pos         <= INIT_TAP_V;
                  done            <= 1'b1;
                  done_status     <= ST_OK;
                  state           <= S_DONE;
               end else begin
                  load_cnt <= load_cnt - 3'd1;
               end
            end

            S_SETUP: begin
               if (remaining == '0) begin
                  done        <= 1'b1;
                  done_status <= ST_OK;
                  state       <= S_DONE;
               end else if (at_limit) begin
                  done        <= 1'b1;
                  done_status <= ST_CLAMP;
                  state       <= S_DONE;
               end else begin
                  delay_line_move <= 1'b1;
                  state           <= S_PULSE;
`ifdef DDR3_ODT_DLY_STATS_EN
                  if (move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
`endif
               end
            end

            S_PULSE: begin
               delay_line_move <= 1'b0;
               gap_cnt         <= 4'(MOVE_GAP - 1);
               state           <= S_GAP;
            end

            S_GAP: begin
               if (gap_cnt == '0) begin
                  if (delay_line_out_of_range) begin
                     done        <= 1'b1;
                     done_status <= ST_OOR;
                     state       <= S_DONE;
`ifdef DDR3_ODT_DLY_STATS_EN
                     if (oor_cnt != 8'hFF) oor_cnt <= oor_cnt + 8'd1;
`endif
                  end else begin
                     tap_pos   <= (delay_line_direction == DIR_INC) ? tap_pos + ONE_V
                                                                    : tap_pos - ONE_V;
                     remaining <= remaining - ONE_V;
                     if (remaining == ONE_V) begin
                        done        <= 1'b1;
                        done_status <= ST_OK;
                        state       <= S_DONE;
                     end else begin
                        state <= S_SETUP;
                     end
                  end
               end else begin
                  gap_cnt <= gap_cnt - 4'd1;
               end
            end

            S_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr3_odt_dly_ctrl.sv
// Self-checking bench for ddr3_odt_dly_ctrl: request table with scoreboard, plus reset corner cases.
module tb_ddr3_odt_dly_ctrl;
   import ddr3_odt_dly_pkg::*;

   localparam int TAP_W = 8;

   logic             fab_clk = 1'b0;
   logic             arst_n;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_load = 1'b0;
   logic             req_dir = 1'b0;
   logic [TAP_W-1:0] req_steps = '0;
   logic             done;
   logic [1:0]       done_status;
   logic             busy;
   logic [TAP_W-1:0] tap_pos;
   logic             delay_line_move;
   logic             delay_line_direction;
   logic             delay_line_load;
   logic             delay_line_out_of_range = 1'b0;
`ifdef DDR3_ODT_DLY_STATS_EN
   logic [15:0]      move_cnt;
   logic [7:0]       oor_cnt;
`endif

   ddr3_odt_dly_ctrl #(
      .TAP_W(TAP_W), .MAX_TAP(255), .INIT_TAP(1), .MOVE_GAP(4), .LOAD_CYCLES(2)
   ) dut (
      .fab_clk                 (fab_clk),
      .arst_n                  (arst_n),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_load                (req_load),
      .req_dir                 (req_dir),
      .req_steps               (req_steps),
      .done                    (done),
      .done_status             (done_status),
      .busy                    (busy),
      .tap_pos                 (tap_pos),
      .delay_line_move         (delay_line_move),
      .delay_line_direction    (delay_line_direction),
      .delay_line_load         (delay_line_load),
`ifdef DDR3_ODT_DLY_STATS_EN
      .move_cnt                (move_cnt),
      .oor_cnt                 (oor_cnt),
`endif
      .delay_line_out_of_range (delay_line_out_of_range)
   );

   always #5 fab_clk = ~fab_clk;

   typedef struct {
      logic       load;
      logic       dir;
      logic [7:0] steps;
      logic       hold;         // keep VALID asserted for the whole busy period
      int         oor_move;     // raise OUT_OF_RANGE after this move pulse (0 = never)
      int         exp_moves;
      int         exp_loads;
      logic [1:0] exp_status;
      logic [7:0] exp_tap;
      int         exp_done_cyc; // negedges after accept until DONE is seen
   } vec_t;

   vec_t vecs[8];
   vec_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   guard;
      int   moves, loads, done_cyc, last_move;
      logic dir0, both_hi, busy_low, ready_hi;
      vec_t e;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge fab_clk);
         guard++;
      end
      check($sformatf("v%0d_ready_wait", idx), req_ready, 1'b1);
      req_valid = 1'b1;
      req_load  = v.load;
      req_dir   = v.dir;
      req_steps = v.steps;
      @(posedge fab_clk);
      sb_q.push_back(v);
      moves = 0; loads = 0; done_cyc = -1; last_move = -1;
      dir0 = 1'b0; both_hi = 1'b0; busy_low = 1'b0; ready_hi = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge fab_clk);
         if (!v.hold) req_valid = 1'b0;
         if (cyc == 0) dir0 = delay_line_direction;
         if (delay_line_move && delay_line_load) both_hi = 1'b1;
         if (!busy) busy_low = 1'b1;
         if (req_ready) ready_hi = 1'b1;
         if (delay_line_load) loads++;
         if (delay_line_move) begin
            moves++;
            if (moves == 1) begin
               check($sformatf("v%0d_first_move_cyc", idx), cyc, 1);
               check($sformatf("v%0d_dir_setup", idx), dir0, v.dir);
               check($sformatf("v%0d_dir_at_move", idx), delay_line_direction, v.dir);
            end else begin
               check($sformatf("v%0d_move_spacing", idx), cyc - last_move, 6);
            end
            last_move = cyc;
            if (moves == v.oor_move) delay_line_out_of_range = 1'b1;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      req_valid = 1'b0;
      delay_line_out_of_range = 1'b0;
      if (done_cyc < 0) begin
         check($sformatf("v%0d_done_timeout", idx), 0, 1);
         return;
      end
      check($sformatf("v%0d_sb_nonempty", idx), sb_q.size() > 0, 1'b1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check($sformatf("v%0d_status", idx), done_status, e.exp_status);
      check($sformatf("v%0d_tap", idx), tap_pos, e.exp_tap);
      check($sformatf("v%0d_moves", idx), moves, e.exp_moves);
      check($sformatf("v%0d_loads", idx), loads, e.exp_loads);
      check($sformatf("v%0d_move_load_overlap", idx), both_hi, 1'b0);
      check($sformatf("v%0d_busy_held", idx), busy_low, 1'b0);
      check($sformatf("v%0d_ready_low_busy", idx), ready_hi, 1'b0);
      if (e.exp_done_cyc >= 0)
         check($sformatf("v%0d_done_cyc", idx), done_cyc, e.exp_done_cyc);
      @(negedge fab_clk);
      check($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
      check($sformatf("v%0d_idle_done", idx), done, 1'b0);
      check($sformatf("v%0d_status_held", idx), done_status, e.exp_status);
   endtask

   initial begin
      int done_seen;
      int guard;
      //         load dir steps hold oor moves loads status   tap done_cyc
      vecs[0] = '{1'b0, 1'b1, 8'd3,  1'b0, 0, 3,  0, ST_OK,    8'd4,  18};
      vecs[1] = '{1'b0, 1'b0, 8'd2,  1'b0, 0, 2,  0, ST_OK,    8'd2,  12};
      vecs[2] = '{1'b0, 1'b0, 8'd5,  1'b0, 0, 2,  0, ST_CLAMP, 8'd0,  13};
      vecs[3] = '{1'b0, 1'b1, 8'd0,  1'b0, 0, 0,  0, ST_OK,    8'd0,  1};
      vecs[4] = '{1'b0, 1'b1, 8'd1,  1'b0, 0, 1,  0, ST_OK,    8'd1,  6};
      vecs[5] = '{1'b0, 1'b1, 8'd4,  1'b0, 2, 2,  0, ST_OOR,   8'd2,  12};
      vecs[6] = '{1'b0, 1'b1, 8'd38, 1'b0, 0, 38, 0, ST_OK,    8'd40, 228};
      vecs[7] = '{1'b1, 1'b0, 8'd5,  1'b1, 0, 0,  2, ST_OK,    8'd1,  2};

      arst_n = 1'b1;
      #1 arst_n = 1'b0;
      #1;
      check("rst_ready", req_ready, 1'b0);
      check("rst_tap", tap_pos, 8'd1);
      check("rst_strobes", {delay_line_move, delay_line_direction, delay_line_load}, 3'b000);
      check("rst_done_busy", {done, busy, done_status}, 4'b0000);
      repeat (2) @(posedge fab_clk);
      @(negedge fab_clk);
      arst_n = 1'b1;
      @(negedge fab_clk);
      check("idle_ready", req_ready, 1'b1);
      check("idle_tap", tap_pos, 8'd1);
      check("idle_strobes", {delay_line_move, delay_line_load}, 2'b00);

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
      check("sb_drained", sb_q.size(), 0);

      // Abort mid-GAP: outputs must fall asynchronously and no DONE may follow.
      @(negedge fab_clk);
      req_valid = 1'b1; req_load = 1'b0; req_dir = 1'b1; req_steps = 8'd3;
      @(negedge fab_clk);
      req_valid = 1'b0;
      guard = 0;
      while (!delay_line_move && guard < 20) begin
         @(negedge fab_clk);
         guard++;
      end
      check("abort_move_seen", delay_line_move, 1'b1);
      repeat (2) @(negedge fab_clk);
      check("abort_busy_before", busy, 1'b1);
      #2 arst_n = 1'b0;
      #1;
      check("abort_strobes", {delay_line_move, delay_line_load, busy}, 3'b000);
      check("abort_tap", tap_pos, 8'd1);
      check("abort_done", {done, done_status}, 3'b000);
`ifdef DDR3_ODT_DLY_STATS_EN
      check("abort_move_cnt", move_cnt, 16'd0);
      check("abort_oor_cnt", oor_cnt, 8'd0);
`endif
      @(posedge fab_clk);
      @(negedge fab_clk);
      arst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge fab_clk);
         if (done || busy || delay_line_move) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_ready", req_ready, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
